// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding architectural HI/LO.
// One radix-2 step per cycle: shift-add multiply, restoring divide.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opb;
    logic [31:0] rs_q;
    logic        op_div;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        signed_op;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [64:0] div_sh;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign dbg_state = state;

    always_comb begin
        signed_op = ~op[0];
        a_mag     = (signed_op && rs_data[31]) ? -rs_data : rs_data;
        b_mag     = (signed_op && rt_data[31]) ? -rt_data : rt_data;

        // Multiply: low half of acc holds the remaining multiplier bits.
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};

        // Divide: a borrow out of the trial subtract means the bit is 0.
        div_sh    = {acc, 1'b0};
        div_trial = div_sh[64:32] - {1'b0, opb};
        div_next  = div_trial[32] ? div_sh[63:0]
                                  : {div_trial[31:0], div_sh[31:1], 1'b1};

        prod_fix  = neg_q ? -acc : acc;
        quo_fix   = neg_q ? -acc[31:0] : acc[31:0];
        rem_fix   = neg_r ? -acc[63:32] : acc[63:32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            acc      <= 64'd0;
            opb      <= 32'd0;
            rs_q     <= 32'd0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div   <= op[1];
                        neg_q    <= signed_op & (rs_data[31] ^ rt_data[31]);
                        neg_r    <= signed_op & rs_data[31];
                        div_zero <= op[1] && (rt_data == 32'd0);
                        rs_q     <= rs_data;
                        opb      <= op[1] ? b_mag : a_mag;
                        acc      <= {32'd0, (op[1] ? a_mag : b_mag)};
                        cnt      <= 5'd31;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                CALC: begin
                    acc <= op_div ? div_next : mul_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) state <= FIN;
                end
                FIN: begin
                    if (!op_div) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else if (div_zero) begin
                        hi <= rs_q;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO, latency and control checks.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res,
                          input bit disturb, input bit with_mtlo);
        int cyc;
        int busy_cnt;
        logic [63:0] e;
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        mtlo    = with_mtlo;
        exp_q.push_back(exp_res);
        @(posedge clk); #1;
        start   = 1'b0;
        mtlo    = 1'b0;
        rs_data = 32'hA5A5_A5A5;
        rt_data = 32'h5A5A_5A5A;
        check({tag, "_done_low_at_issue"}, {31'd0, done}, 32'd0);
        cyc = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < 60) begin
            if (busy === 1'b1) busy_cnt++;
            if (disturb && cyc == 5) begin
                start   = 1'b1;
                mtlo    = 1'b1;
                op      = 2'b11;
                rs_data = 32'hDEAD_BEEF;
                rt_data = 32'd3;
            end
            if (cyc == 6) begin
                start = 1'b0;
                mtlo  = 1'b0;
            end
            if (cyc == 16) begin
                check({tag, "_hi_hold"}, hi, model_hi);
                check({tag, "_lo_hold"}, lo, model_lo);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd33);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
        check({tag, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
        e = exp_q.pop_front();
        check({tag, "_hi"}, hi, e[63:32]);
        check({tag, "_lo"}, lo, e[31:0]);
        model_hi = e[63:32];
        model_lo = e[31:0];
    endtask

    initial begin
        int done_cnt;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = 32'd0;
        rt_data = 32'd0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);

        run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0);
        // The done cycle must be one cycle wide; the next issue re-checks it.
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, {32'd2, 32'hE}, 0, 0);
        run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0, 0);
        run_op("divu_by0", 2'b11, 32'd42, 32'd0, {32'd42, 32'hFFFF_FFFF}, 0, 0);

        @(posedge clk); #1;
        check("done_pulse_width", {31'd0, done}, 32'd0);

        mthi    = 1'b1;
        rs_data = 32'h1234_5678;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo_kept", lo, 32'hFFFF_FFFF);

        mthi    = 1'b1;
        mtlo    = 1'b1;
        rs_data = 32'h0BAD_F00D;
        @(posedge clk); #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi_mtlo_hi", hi, 32'h0BAD_F00D);
        check("mthi_mtlo_lo", lo, 32'h0BAD_F00D);
        model_hi = 32'h0BAD_F00D;
        model_lo = 32'h0BAD_F00D;

        run_op("multu_disturb", 2'b01, 32'd3, 32'd4, {32'd0, 32'd12}, 1, 0);
        run_op("divu_with_mtlo", 2'b11, 32'd1000, 32'd10, {32'd0, 32'd100}, 0, 1);

        start   = 1'b1;
        op      = 2'b00;
        rs_data = 32'd9;
        rt_data = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        run_op("mult_6x7", 2'b00, 32'd6, 32'd7, {32'd0, 32'd42}, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
